// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display path.
// Blank reset value depends on BCD_LZ_BLANK_EN (leading-zero blanking build).
package display_pkg;

    localparam int NDIGITS = 8;
    localparam int BCD_MAX = 99_999_999;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } fmt_state_t;

`ifdef BCD_LZ_BLANK_EN
    // Only the units digit lit, so an idle display reads "0".
    localparam logic [NDIGITS-1:0] BLANK_RST = 8'hFE;
`else
    localparam logic [NDIGITS-1:0] BLANK_RST = 8'h00;
`endif
    localparam logic [NDIGITS-1:0] DPMASK_RST = 8'h00;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import display_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_display_formatter.sv
// Iterative binary-to-BCD formatter feeding the eight-digit display controller.
// Leading-zero blanking is built only when BCD_LZ_BLANK_EN is defined.
module bcd_display_formatter
    import display_pkg::*;
#(
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    input  logic             dp_en,
    input  logic [2:0]       dp_pos,
    output logic             busy,
    output logic             done,
    output logic [3:0]       d7,
    output logic [3:0]       d6,
    output logic [3:0]       d5,
    output logic [3:0]       d4,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0,
    output logic [7:0]       blank,
    output logic [7:0]       dpmask,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int ACC_W = 4 * NDIGITS;

    fmt_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               dp_en_q, dp_en_d;
    logic [2:0]         dp_pos_q, dp_pos_d;
    logic               ovf_cap_q, ovf_cap_d;

    logic [ACC_W-1:0]   disp_q, disp_d;
    logic [NDIGITS-1:0] blank_q, blank_d;
    logic [NDIGITS-1:0] dpmask_q, dpmask_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [ACC_W-1:0]   acc_adj;
    logic [NDIGITS-1:0] lz_blank;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

`ifdef BCD_LZ_BLANK_EN
    // Scan from the most significant digit; a digit blanks while everything above it is zero.
    always_comb begin
        logic all_zero;
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero && (acc_q[4*i +: 4] == 4'd0);
            lz_blank[i] = all_zero && (i != 0) && !(dp_en_q && (3'(i) <= dp_pos_q));
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        dp_en_d   = dp_en_q;
        dp_pos_d  = dp_pos_q;
        ovf_cap_d = ovf_cap_q;
        disp_d    = disp_q;
        blank_d   = blank_q;
        dpmask_d  = dpmask_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = bin;
                    acc_d     = '0;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    dp_en_d   = dp_en;
                    dp_pos_d  = dp_pos;
                    ovf_cap_d = (bin > WIDTH'(BCD_MAX));
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Carry out of digit 7 is dropped; overflow substitutes the result anyway.
                acc_d = {acc_adj[ACC_W-2:0], sr_q[WIDTH-1]};
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOAD: begin
                disp_d   = ovf_cap_q ? {NDIGITS{4'd9}} : acc_q;
                blank_d  = ovf_cap_q ? '0 : lz_blank;
                dpmask_d = dp_en_q ? (NDIGITS'(1) << dp_pos_q) : '0;
                ovf_d    = ovf_cap_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            disp_q   <= '0;
            blank_q  <= BLANK_RST;
            dpmask_q <= DPMASK_RST;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            disp_q   <= disp_d;
            blank_q  <= blank_d;
            dpmask_q <= dpmask_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Working datapath is always rewritten on an accepted start, so it needs no reset.
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        sr_q      <= sr_d;
        acc_q     <= acc_d;
        dp_en_q   <= dp_en_d;
        dp_pos_q  <= dp_pos_d;
        ovf_cap_q <= ovf_cap_d;
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign blank    = blank_q;
    assign dpmask   = dpmask_q;
    assign overflow = ovf_q;
    assign d0 = disp_q[3:0];
    assign d1 = disp_q[7:4];
    assign d2 = disp_q[11:8];
    assign d3 = disp_q[15:12];
    assign d4 = disp_q[19:16];
    assign d5 = disp_q[23:20];
    assign d6 = disp_q[27:24];
    assign d7 = disp_q[31:28];

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Self-checking bench for bcd_display_formatter: decimal reference model plus directed vectors.
// Blank expectations follow BCD_LZ_BLANK_EN the same way the design build does.
module tb_bcd_display_formatter;

    localparam int W = 27;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] bin = '0;
    logic         dp_en = 1'b0;
    logic [2:0]   dp_pos = 3'd0;
    logic         busy, done, overflow;
    logic [3:0]   d7, d6, d5, d4, d3, d2, d1, d0;
    logic [7:0]   blank, dpmask;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

`ifdef BCD_LZ_BLANK_EN
    localparam logic [7:0] EXP_BLANK_RST = 8'hFE;
    localparam logic [7:0] EXP_BLANK_42  = 8'hF8;
`else
    localparam logic [7:0] EXP_BLANK_RST = 8'h00;
    localparam logic [7:0] EXP_BLANK_42  = 8'h00;
`endif

    bcd_display_formatter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .dp_en(dp_en), .dp_pos(dp_pos),
        .busy(busy), .done(done),
        .d7(d7), .d6(d6), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .blank(blank), .dpmask(dpmask), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dig;
        logic [7:0]  blank;
        logic [7:0]  dpm;
        logic        ovf;
    } disp_t;

    // Reference: decimal digits by repeated division, blanking by a digit scan.
    function automatic disp_t model(input logic [W-1:0] b, input logic e, input logic [2:0] p);
        disp_t   r;
        longint  v;
        bit      seen;
        v     = longint'(b);
        r.ovf = (v > 64'd99999999);
        for (int i = 0; i < 8; i++) begin
            r.dig[4*i +: 4] = r.ovf ? 4'd9 : 4'(v % 10);
            v = v / 10;
        end
        r.dpm   = e ? (8'd1 << p) : 8'h00;
        r.blank = 8'h00;
`ifdef BCD_LZ_BLANK_EN
        seen = 1'b0;
        if (!r.ovf) begin
            for (int i = 7; i >= 1; i--) begin
                if (r.dig[4*i +: 4] != 4'd0) seen = 1'b1;
                if (!seen && !(e && (i <= int'(p)))) r.blank[i] = 1'b1;
            end
        end
`else
        seen = 1'b0;
`endif
        return r;
    endfunction

    disp_t exp_q, pend_q;
    int    tleft = 0;
    logic  exp_done = 1'b0;

    // Transaction-level timing: an accepted start yields results WIDTH+2 cycles later.
    always @(posedge clk) begin
        if (rst) begin
            tleft    <= 0;
            exp_done <= 1'b0;
            exp_q    <= '{dig: 32'h0, blank: EXP_BLANK_RST, dpm: 8'h00, ovf: 1'b0};
        end else begin
            exp_done <= 1'b0;
            if (tleft > 0) begin
                tleft <= tleft - 1;
                if (tleft == 1) begin
                    exp_q    <= pend_q;
                    exp_done <= 1'b1;
                end
            end else if (start) begin
                pend_q <= model(bin, dp_en, dp_pos);
                tleft  <= W + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_busy", 32'(busy), 32'(tleft != 0));
                check("cyc_done", 32'(done), 32'(exp_done));
                check("cyc_digits", {d7, d6, d5, d4, d3, d2, d1, d0}, exp_q.dig);
                check("cyc_blank", 32'(blank), 32'(exp_q.blank));
                check("cyc_dpmask", 32'(dpmask), 32'(exp_q.dpm));
                check("cyc_overflow", 32'(overflow), 32'(exp_q.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] b, input logic e, input logic [2:0] p);
        start = 1'b1; bin = b; dp_en = e; dp_pos = p;
        tick();
        start = 1'b0;
    endtask

    // Called one cycle after acceptance; returns cycles since acceptance and busy count.
    task automatic wait_done(output int n, output int bc);
        n  = 1;
        bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            tick();
            n++;
        end
        if (!done) $display("FAIL wait_done timeout after %0d cycles", n);
    endtask

    function automatic logic [31:0] digs();
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    int n, bc, dcount;

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        cmp_en = 1'b1;
        rst = 1'b0;
        tick();
        check("rst_digits", digs(), 32'h0);
        check("rst_blank", 32'(blank), 32'(EXP_BLANK_RST));
        check("rst_dpmask", 32'(dpmask), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);

        do_start(27'd12345678, 1'b0, 3'd0);
        wait_done(n, bc);
        check("lat_12345678", 32'(n), 32'd29);
        check("busy_cycles", 32'(bc), 32'd28);
        check("dig_12345678", digs(), 32'h12345678);
        check("blank_12345678", 32'(blank), 32'h00);
        check("ovf_12345678", 32'(overflow), 32'h0);
        tick();
        check("done_one_cycle", 32'(done), 32'h0);
        check("hold_12345678", digs(), 32'h12345678);

        do_start(27'd42, 1'b1, 3'd2);
        wait_done(n, bc);
        check("dig_42", digs(), 32'h00000042);
        check("blank_42", 32'(blank), 32'(EXP_BLANK_42));
        check("dpmask_42", 32'(dpmask), 32'h04);

        do_start(27'd99999999, 1'b0, 3'd0);
        wait_done(n, bc);
        check("dig_max", digs(), 32'h99999999);
        check("ovf_max", 32'(overflow), 32'h0);
        check("dpmask_cleared", 32'(dpmask), 32'h00);

        do_start(27'd100000000, 1'b1, 3'd7);
        wait_done(n, bc);
        check("dig_ovf", digs(), 32'h99999999);
        check("ovf_ovf", 32'(overflow), 32'h1);
        check("blank_ovf", 32'(blank), 32'h00);
        check("dpmask_ovf", 32'(dpmask), 32'h80);

        do_start(27'd5, 1'b0, 3'd0);
        repeat (5) tick();
        start = 1'b1; bin = 27'd77; dp_en = 1'b1; dp_pos = 3'd1;
        tick();
        start = 1'b0;
        n = 7;
        while (!done && n < 100) begin tick(); n++; end
        check("lat_ignored", 32'(n), 32'd29);
        check("dig_ignored", digs(), 32'h00000005);
        check("dpmask_ignored", 32'(dpmask), 32'h00);

        do_start(27'd1000, 1'b1, 3'd0);
        wait_done(n, bc);
        check("lat_b2b", 32'(n), 32'd29);
        check("dig_1000", digs(), 32'h00001000);
        check("dpmask_1000", 32'(dpmask), 32'h01);

        do_start(27'd87654321, 1'b0, 3'd0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_digits", digs(), 32'h0);
        check("abort_blank", 32'(blank), 32'(EXP_BLANK_RST));
        check("abort_busy", 32'(busy), 32'h0);
        dcount = 0;
        repeat (40) begin
            if (done) dcount++;
            tick();
        end
        check("abort_no_done", 32'(dcount), 32'h0);

        do_start(27'd0, 1'b0, 3'd0);
        wait_done(n, bc);
        check("lat_zero", 32'(n), 32'd29);
        check("dig_zero", digs(), 32'h0);
        check("blank_zero", 32'(blank), 32'(EXP_BLANK_RST));

        do_start(27'd7005, 1'b1, 3'd5);
        wait_done(n, bc);
        check("dig_7005", digs(), 32'h00007005);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_formatter.md
# bcd_display_formatter

Sequential binary-to-BCD formatter that sits directly upstream of the eight-digit seven-segment display controller. It takes an unsigned binary value on a start strobe and converts it with an iterative double-dabble (shift/add-3) engine, one bit per cycle. It then produces the eight 4-bit digit nibbles, the active-high per-digit blank mask and the decimal-point mask that the display controller consumes. All display outputs update atomically at the end of a conversion, so the display never shows a partial result.

## Interface
- WIDTH, 27: width of binary input; must be ≥ 27 so 99_999_999 is representable.
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request conversion; sampled only in IDLE
- bin  input  WIDTH  unsigned value; captured on accepted start
- dp_en  input  1  decimal point enable; captured with bin
- dp_pos  input  3  digit index (0 = rightmost) carrying the decimal point; captured with bin
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse: new display outputs valid
- d7..d0  output  4 each  BCD digits, d7 most significant
- blank  output  8  active-high blank per digit, to display controller
- dpmask  output  8  one-hot decimal-point mask, to display controller
- overflow  output  1  last captured bin exceeded 99_999_999

## Operation
- States: IDLE, SHIFT, LOAD.
- IDLE, start=1: capture bin, dp_en and dp_pos, and clear the 32-bit BCD accumulator. Load the shift counter with WIDTH-1, then go to SHIFT.
- IDLE, start=0: remain in IDLE.
- SHIFT, each cycle: for every accumulator digit ≥5, add 3. Then shift {accumulator, shift register} left by one, with the MSB of bin entering accumulator bit 0.
- SHIFT: when the counter reaches 0, go to LOAD. Otherwise decrement the counter.
- Accumulator arithmetic is 32 bits. Carries out of digit 7 are discarded, because overflow handling replaces the result.
- LOAD: write d7..d0, blank, dpmask and overflow from the accumulator and the captured controls, then go to IDLE.
- Overflow is evaluated on the captured bin: bin > 99_999_999. On overflow, all digits = 9, blank = 8'h00, overflow = 1.
- dpmask = dp_en ? (8'b1 << dp_pos) : 8'h00.
- Leading-zero blanking: blank[i] = 1 iff every digit j ≥ i is zero, subject to these exceptions:
  - Digit 0 is never blanked.
  - When dp_en = 1, digits i ≤ dp_pos are never blanked.
- start while busy: ignored, with no queuing.
- Reset values: busy 0, done 0, d7..d0 all 4'h0, blank 8'hFE (display shows "0"), dpmask 8'h00, overflow 0, state IDLE.
- rst mid-conversion aborts the conversion. All outputs return to reset values and no done pulse is produced.

## Timing
- start accepted in cycle t (state IDLE).
- busy = 1 in cycles t+1 .. t+WIDTH+1:
  - SHIFT occupies t+1 .. t+WIDTH.
  - LOAD occupies t+WIDTH+1.
- New outputs and done = 1 appear in cycle t+WIDTH+2. With default WIDTH, that is t+29.
- Back-to-back: start may be asserted in the same cycle done is high; it is accepted.
- Display outputs are registered and hold their value between conversions. Their only change points are LOAD and reset.
- No combinational path exists from any input to any output.

## Configuration
- BCD_LZ_BLANK_EN defined: leading-zero blanking as described above.
- BCD_LZ_BLANK_EN undefined: blank is held at 8'h00 after LOAD. The reset value is then also 8'h00, so all eight digits are shown, including leading zeros.
- dpmask and overflow behaviour are identical in both builds.

## Structure
- Shared package display_pkg contains:
  - NDIGITS = 8
  - BCD_MAX = 99_999_999
  - typedef bcd_digit_t (logic [3:0])
  - state enum fmt_state_t {IDLE, SHIFT, LOAD}
  - reset constants for blank and dpmask
- Sub-module bcd_digit_adj: combinational per-digit "≥5 → +3" correction, instantiated 8 times in a generate loop.
- Blank-mask generation stays inline in the top module under the macro.

## Test plan
- After reset, no start → d=00000000, blank=FE, dpmask=00, busy=0, done=0. Build without the macro → blank=00.
- bin=12345678, start in cycle t → done only in cycle t+29; d7..d0=1,2,3,4,5,6,7,8; blank=00; overflow=0; busy high for exactly 28 cycles.
- bin=42, dp_en=1, dp_pos=2 → d=00000042, blank=F8, dpmask=04 (displays "0.42").
- bin=99_999_999 → all digits 9, overflow=0. bin=100_000_000 → all digits 9, overflow=1, blank=00.
- Second start pulsed mid-conversion with a different bin → ignored, first result shown; start in the done cycle → accepted, done again exactly 29 cycles later.
- rst asserted in SHIFT cycle 10 → outputs at reset values next cycle, no done pulse; subsequent bin=0 → d=0, blank=FE.
